// File: rtl/l2_ifetch_pkg.sv
// Shared types and widths for the L2 instruction-fetch responder.
// The optional line buffer is enabled with the L2_IFETCH_LINEBUF_EN macro.
package l2_ifetch_pkg;

    localparam int TAG_W      = 18;
    localparam int IDX_W      = 8;
    localparam int OFF_W      = 6;
    localparam int ADDR_W     = 32;
    localparam int LADDR_W    = TAG_W + IDX_W;
    localparam int LINE_W_DEF = 512;
    localparam int BEAT_W_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEM_REQ,
        ST_MEM_FILL,
        ST_RESP,
        ST_GAP
    } state_t;

    // Line-aligned byte address from a {tag, index} line address.
    function automatic logic [ADDR_W-1:0] line_byte_addr(input logic [LADDR_W-1:0] line_addr);
        return {line_addr, {OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/l2_ifetch_line_buf.sv
// Line register with per-beat write port, plus the one-entry buffer tag/valid
// and hit compare that exist only when L2_IFETCH_LINEBUF_EN is defined.
module l2_ifetch_line_buf
    import l2_ifetch_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int BEAT_W = BEAT_W_DEF,
    parameter int CNT_W  = 3
)
(
    input  logic               clk,
    input  logic               nrst,
    input  logic               i_flush,
    input  logic [LADDR_W-1:0] i_lookup_addr,
    output logic               o_hit,
    input  logic               i_fill_start,
    input  logic               i_beat_we,
    input  logic [CNT_W-1:0]   i_beat_idx,
    input  logic [BEAT_W-1:0]  i_beat_data,
    input  logic               i_fill_last,
    input  logic [LADDR_W-1:0] i_fill_addr,
    output logic [LINE_W-1:0]  o_line
);

    localparam int NBEATS = LINE_W / BEAT_W;

    logic [LINE_W-1:0] r_line;
    logic [NBEATS-1:0] w_beat_sel;

    generate
        for (genvar gi = 0; gi < NBEATS; gi++) begin : g_beat_sel
            assign w_beat_sel[gi] = i_beat_we && (i_beat_idx == CNT_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_line <= '0;
        end else begin
            for (int i = 0; i < NBEATS; i++) begin
                if (w_beat_sel[i]) begin
                    r_line[i*BEAT_W +: BEAT_W] <= i_beat_data;
                end
            end
        end
    end

    assign o_line = r_line;

`ifdef L2_IFETCH_LINEBUF_EN
    logic               r_valid;
    logic               r_flushed;
    logic [LADDR_W-1:0] r_addr;

    // r_flushed remembers a flush seen since the fill started, so the
    // refilled line is returned but never marked reusable.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_valid   <= 1'b0;
            r_flushed <= 1'b0;
            r_addr    <= '0;
        end else begin
            if (i_fill_start) begin
                r_flushed <= 1'b0;
            end else if (i_flush) begin
                r_flushed <= 1'b1;
            end
            if (i_flush) begin
                r_valid <= 1'b0;
            end else if (i_fill_last && !r_flushed) begin
                r_valid <= 1'b1;
            end
            if (i_fill_last) begin
                r_addr <= i_fill_addr;
            end
        end
    end

    assign o_hit = r_valid && !i_flush && (r_addr == i_lookup_addr);
`else
    logic w_unused;
    assign w_unused = ^{i_flush, i_lookup_addr, i_fill_start, i_fill_last, i_fill_addr};
    assign o_hit    = 1'b0;
`endif

endmodule

// File: rtl/l2_ifetch_responder.sv
// L2-side refill responder: fetches a line over a narrow beat bus and returns it
// with a one-cycle ready pulse. Line-buffer hit path built with L2_IFETCH_LINEBUF_EN.
module l2_ifetch_responder
    import l2_ifetch_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int BEAT_W = BEAT_W_DEF
)
(
    input  logic               clk,
    input  logic               nrst,
    input  logic               read_L1_L2,
    input  logic [TAG_W-1:0]   tag_L1_L2,
    input  logic [IDX_W-1:0]   index_L1_L2,
    input  logic               flush,
    output logic               ready_L2_L1,
    output logic [LINE_W-1:0]  read_data_L2_L1,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [BEAT_W-1:0]  mem_rdata
);

    localparam int NBEATS = LINE_W / BEAT_W;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    state_t             r_state;
    state_t             w_state_next;
    logic [LADDR_W-1:0] r_req_addr;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic               w_lookup;
    logic               w_hit;
    logic               w_fill_start;
    logic               w_fill_we;
    logic               w_fill_last;
    logic               w_gnt_taken;

    assign w_lookup     = (r_state == ST_IDLE) && read_L1_L2;
    assign w_fill_start = w_lookup && !w_hit;
    assign w_gnt_taken  = (r_state == ST_MEM_REQ) && mem_gnt;
    assign w_fill_we    = (r_state == ST_MEM_FILL) && mem_rvalid;
    assign w_fill_last  = w_fill_we && (r_beat_cnt == CNT_W'(NBEATS - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:     if (read_L1_L2) w_state_next = w_hit ? ST_RESP : ST_MEM_REQ;
            ST_MEM_REQ:  if (mem_gnt)    w_state_next = ST_MEM_FILL;
            ST_MEM_FILL: if (w_fill_last) w_state_next = ST_RESP;
            ST_RESP:     w_state_next = ST_GAP;
            ST_GAP:      w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= ST_IDLE;
            r_req_addr <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_lookup) begin
                r_req_addr <= {tag_L1_L2, index_L1_L2};
            end
            if (w_gnt_taken) begin
                r_beat_cnt <= '0;
            end else if (w_fill_we) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    l2_ifetch_line_buf #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W),
        .CNT_W  (CNT_W)
    ) u_line_buf (
        .clk           (clk),
        .nrst          (nrst),
        .i_flush       (flush),
        .i_lookup_addr ({tag_L1_L2, index_L1_L2}),
        .o_hit         (w_hit),
        .i_fill_start  (w_fill_start),
        .i_beat_we     (w_fill_we),
        .i_beat_idx    (r_beat_cnt),
        .i_beat_data   (mem_rdata),
        .i_fill_last   (w_fill_last),
        .i_fill_addr   (r_req_addr),
        .o_line        (read_data_L2_L1)
    );

    assign ready_L2_L1 = (r_state == ST_RESP);
    assign mem_req     = (r_state == ST_MEM_REQ);
    assign mem_addr    = line_byte_addr(r_req_addr);

endmodule

// File: tb/tb_l2_ifetch_responder.sv
// Randomized self-checking bench for l2_ifetch_responder; expectations follow the
// request/refill timeline and a one-entry buffer model (L2_IFETCH_LINEBUF_EN aware).
module tb_l2_ifetch_responder;

    localparam int NBEATS = 8;
`ifdef L2_IFETCH_LINEBUF_EN
    localparam bit LINEBUF_EN = 1'b1;
`else
    localparam bit LINEBUF_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic         read_L1_L2 = 1'b0;
    logic [17:0]  tag_L1_L2 = '0;
    logic [7:0]   index_L1_L2 = '0;
    logic         flush = 1'b0;
    logic         ready_L2_L1;
    logic [511:0] read_data_L2_L1;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_gnt = 1'b0;
    logic         mem_rvalid = 1'b0;
    logic [63:0]  mem_rdata = '0;

    l2_ifetch_responder dut (
        .clk             (clk),
        .nrst            (nrst),
        .read_L1_L2      (read_L1_L2),
        .tag_L1_L2       (tag_L1_L2),
        .index_L1_L2     (index_L1_L2),
        .flush           (flush),
        .ready_L2_L1     (ready_L2_L1),
        .read_data_L2_L1 (read_data_L2_L1),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_gnt         (mem_gnt),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata)
    );

    always #5 clk = ~clk;

    // Reference model: the line the block must be holding, and the reusable entry.
    bit           m_valid = 1'b0;
    bit           m_flushed = 1'b0;
    logic [25:0]  m_addr = '0;
    logic [511:0] m_line = '0;

    // Per-cycle expectations set by the stimulus timeline.
    bit           chk_en = 1'b0;
    bit           exp_ready = 1'b0;
    bit           exp_mem_req = 1'b0;
    bit           exp_data_chk = 1'b0;
    logic [31:0]  exp_addr = '0;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           req_cyc = 0;
    int           last_ready_cyc = 0;
    int           n_ready = 0;
    int           n_fetch = 0;
    int           exp_pulses = 0;
    logic [31:0]  last_req_addr = '0;
    logic [511:0] last_ready_data = '0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", 512'(ready_L2_L1), 512'(exp_ready));
            check("mem_req", 512'(mem_req), 512'(exp_mem_req));
            if (exp_mem_req) check("mem_addr", 512'(mem_addr), 512'(exp_addr));
            if (exp_data_chk) check("read_data", read_data_L2_L1, m_line);
            if (ready_L2_L1) begin
                last_ready_cyc  = cyc;
                last_ready_data = read_data_L2_L1;
                n_ready++;
            end
            if (mem_req) last_req_addr = mem_addr;
            if (mem_req && mem_gnt) n_fetch++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n, input bit det);
        for (int i = 0; i < n; i++) begin
            read_L1_L2 = 1'b0;
            exp_ready = 1'b0; exp_mem_req = 1'b0; exp_data_chk = 1'b1;
            mem_rvalid = det ? 1'b0 : 1'($urandom_range(0, 1));
            mem_gnt    = det ? 1'b0 : 1'($urandom_range(0, 1));
            mem_rdata  = {$urandom, $urandom};
            flush = 1'b0;
            if (!det && $urandom_range(0, 5) == 0) begin flush = 1'b1; m_valid = 1'b0; end
            step();
        end
        flush = 1'b0; mem_rvalid = 1'b0; mem_gnt = 1'b0;
    endtask

    task automatic reset_mid();
        chk_en = 1'b0;
        mem_rvalid = 1'b0; mem_gnt = 1'b0; read_L1_L2 = 1'b0; flush = 1'b0;
        #1 nrst = 1'b0;
        #1;
        check("rst_ready", 512'(ready_L2_L1), 512'(0));
        check("rst_mem_req", 512'(mem_req), 512'(0));
        check("rst_mem_addr", 512'(mem_addr), 512'(0));
        check("rst_data", read_data_L2_L1, 512'(0));
        m_valid = 1'b0;
        m_line  = '0;
        @(posedge clk);
        #2 nrst = 1'b1;
        step();
        exp_ready = 1'b0; exp_mem_req = 1'b0; exp_data_chk = 1'b1;
        chk_en = 1'b1;
    endtask

    task automatic do_txn(input logic [17:0] tag, input logic [7:0] idx, input bit det,
                          input logic [63:0] base, input bit flush_req, input int flush_beat,
                          input int rst_beat, input int gnt_dly);
        bit          hit;
        logic [63:0] beat;
        read_L1_L2 = 1'b1; tag_L1_L2 = tag; index_L1_L2 = idx; flush = flush_req;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        exp_ready = 1'b0; exp_mem_req = 1'b0; exp_data_chk = 1'b1;
        req_cyc = cyc;
        hit = LINEBUF_EN && m_valid && (m_addr == {tag, idx}) && !flush_req;
        if (flush_req) m_valid = 1'b0;
        step();
        flush = 1'b0;
        if (!hit) begin
            m_flushed = 1'b0;
            for (int d = 0; d <= gnt_dly; d++) begin
                exp_mem_req = 1'b1; exp_addr = {tag, idx, 6'b0};
                mem_gnt    = (d == gnt_dly);
                mem_rvalid = det ? 1'b0 : 1'($urandom_range(0, 1));
                mem_rdata  = {$urandom, $urandom};
                flush = 1'b0;
                if (!det && $urandom_range(0, 7) == 0) begin
                    flush = 1'b1; m_valid = 1'b0; m_flushed = 1'b1;
                end
                step();
            end
            exp_mem_req = 1'b0; exp_data_chk = 1'b0; mem_gnt = 1'b0; flush = 1'b0;
            for (int k = 0; k < NBEATS; k++) begin
                if (!det) begin
                    repeat ($urandom_range(0, 2)) begin
                        mem_rvalid = 1'b0; mem_gnt = 1'($urandom_range(0, 1));
                        step();
                    end
                end
                if (k == rst_beat) begin
                    reset_mid();
                    return;
                end
                beat = det ? base + 64'(k) : {$urandom, $urandom};
                mem_rvalid = 1'b1; mem_rdata = beat; mem_gnt = 1'b0;
                m_line[k*64 +: 64] = beat;
                if (k == flush_beat) begin
                    flush = 1'b1; m_valid = 1'b0; m_flushed = 1'b1;
                end
                step();
                flush = 1'b0; mem_rvalid = 1'b0; mem_gnt = 1'b0;
            end
            if (!m_flushed) m_valid = 1'b1;
            m_addr = {tag, idx};
        end
        // Response cycle
        exp_ready = 1'b1; exp_data_chk = 1'b1; exp_mem_req = 1'b0;
        mem_rvalid = det ? 1'b0 : 1'($urandom_range(0, 1));
        mem_rdata  = {$urandom, $urandom};
        if (!det && $urandom_range(0, 7) == 0) begin flush = 1'b1; m_valid = 1'b0; end
        exp_pulses++;
        step();
        // Gap cycle: request may still be seen high and must be ignored
        exp_ready = 1'b0; flush = 1'b0; mem_rvalid = 1'b0;
        read_L1_L2 = det ? 1'b0 : 1'($urandom_range(0, 1));
        if (!det && $urandom_range(0, 7) == 0) begin flush = 1'b1; m_valid = 1'b0; end
        step();
        read_L1_L2 = 1'b0; flush = 1'b0;
        idle_cycles(det ? 0 : $urandom_range(0, 2), det);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [17:0]  pool_tag [4];
        logic [7:0]   pool_idx [4];
        logic [511:0] lit_line;
        int           f0;
        int           sel;

        lit_line = 512'h0000000000000007_0000000000000006_0000000000000005_0000000000000004_0000000000000003_0000000000000002_0000000000000001_0000000000000000;

        #12;
        check("reset_ready", 512'(ready_L2_L1), 512'(0));
        check("reset_mem_req", 512'(mem_req), 512'(0));
        check("reset_mem_addr", 512'(mem_addr), 512'(0));
        check("reset_data", read_data_L2_L1, 512'(0));
        #1 nrst = 1'b1;
        step();
        exp_ready = 1'b0; exp_mem_req = 1'b0; exp_data_chk = 1'b1;
        chk_en = 1'b1;
        idle_cycles(2, 1'b1);

        // Plain miss from the refill example
        f0 = n_fetch;
        do_txn(18'h00012, 8'h34, 1'b1, 64'h0, 1'b0, -1, -1, 2);
        check("miss_latency", 512'(last_ready_cyc - req_cyc), 512'(12));
        check("miss_addr", 512'(last_req_addr), 512'(32'h0004_8D00));
        check("miss_data", last_ready_data, lit_line);
        check("miss_fetches", 512'(n_fetch - f0), 512'(1));

        // Same line again: served from the buffer only when it is built
        f0 = n_fetch;
        do_txn(18'h00012, 8'h34, 1'b1, 64'h0, 1'b0, -1, -1, 2);
        check("repeat_latency", 512'(last_ready_cyc - req_cyc), 512'(LINEBUF_EN ? 1 : 12));
        check("repeat_fetches", 512'(n_fetch - f0), 512'(LINEBUF_EN ? 0 : 1));
        check("repeat_data", last_ready_data, lit_line);

        // Flush at beat 3: line still returned, next identical request misses
        do_txn(18'h000ab, 8'h11, 1'b1, 64'h100, 1'b0, 3, -1, 0);
        check("flush_latency", 512'(last_ready_cyc - req_cyc), 512'(10));
        f0 = n_fetch;
        do_txn(18'h000ab, 8'h11, 1'b1, 64'h400, 1'b0, -1, -1, 0);
        check("after_flush_fetches", 512'(n_fetch - f0), 512'(1));

        // Reset at beat 5, then a complete miss to the same line
        do_txn(18'h3ffff, 8'hff, 1'b1, 64'h200, 1'b0, -1, 5, 1);
        f0 = n_fetch;
        do_txn(18'h3ffff, 8'hff, 1'b1, 64'h300, 1'b0, -1, -1, 1);
        check("after_reset_latency", 512'(last_ready_cyc - req_cyc), 512'(11));
        check("after_reset_fetches", 512'(n_fetch - f0), 512'(1));
        check("after_reset_addr", 512'(last_req_addr), 512'(32'hFFFF_FFC0));

        // Randomized traffic over a small address pool so hits recur
        for (int i = 0; i < 4; i++) begin
            pool_tag[i] = 18'($urandom);
            pool_idx[i] = 8'($urandom);
        end
        for (int t = 0; t < 80; t++) begin
            sel = $urandom_range(0, 3);
            do_txn(pool_tag[sel], pool_idx[sel], 1'b0, 64'h0,
                   ($urandom_range(0, 9) == 0),
                   ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : -1,
                   -1, $urandom_range(0, 3));
        end

        check("ready_pulses", 512'(n_ready), 512'(exp_pulses));
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
